bus_credit_scheduler: RTL and testbench

//  Central scheduler for the shared packet bus between DRVS driver-side FIFOs.
//  - Round-robin arbitration among sources with pending data; pops one packet per grant.
//  - Decodes the destination ID field and pushes the packet to the destination FIFO.
//  - Enforces per-destination credit flow control so destination FIFOs never overflow.

---
 rtl/bus_credit_scheduler.sv | 162 ++++++++++++++++
 tb/tb_bus_credit_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_credit_scheduler.sv
// Round-robin scheduler moving packets from source FIFOs to credit-controlled destination FIFOs.
// Define BUS_BCAST_EN to enable broadcast delivery for destination ID BCAST_ID.
module bus_credit_scheduler #(
  parameter int              WIDTH    = 16,
  parameter int              DRVS     = 8,
  parameter int              ID_W     = 8,
  parameter logic [ID_W-1:0] BCAST_ID = 8'hFF,
  parameter int              CREDITS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DRVS-1:0]        pndng,
  input  logic [DRVS*WIDTH-1:0]  D_pop,
  output logic [DRVS-1:0]        pop,
  output logic [DRVS-1:0]        push,
  output logic [WIDTH-1:0]       D_push,
  input  logic [DRVS-1:0]        credit_ret,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);
  localparam int IDX_W = $clog2(DRVS);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_DECODE, S_PUSH, S_WAIT, S_DROP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] g_q, g_d, rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] pkt_q, pkt_d, d_push_q, d_push_d;
  logic [DRVS-1:0]  pop_q, pop_d, push_q, push_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [3:0]       credit_q [DRVS];
  logic [3:0]       credit_d [DRVS];

  logic [IDX_W-1:0] win, cand;
  logic             found;
  logic [ID_W-1:0]  dest;
  logic [DRVS-1:0]  dest_mask;
  logic             dest_valid, credit_ok;

  // Destination decode of the captured packet; the mask is stable while waiting for credit.
  always_comb begin
    dest       = pkt_q[WIDTH-1 -: ID_W];
    dest_mask  = '0;
    dest_valid = 1'b0;
    if (dest < ID_W'(DRVS)) begin
      dest_mask[dest[IDX_W-1:0]] = 1'b1;
      dest_valid = 1'b1;
    end
`ifdef BUS_BCAST_EN
    else if (dest == BCAST_ID) begin
      dest_mask  = ~(DRVS'(1) << g_q);
      dest_valid = 1'b1;
    end
`else
    else if (dest == BCAST_ID) begin
      dest_valid = 1'b0;
    end
`endif
    credit_ok = 1'b1;
    for (int i = 0; i < DRVS; i++) begin
      if (dest_mask[i] && credit_q[i] == 4'd0) credit_ok = 1'b0;
    end
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= DRVS; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % DRVS);
      if (!found && pndng[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_d      = pkt_q;
    d_push_d   = d_push_q;
    drop_cnt_d = drop_cnt_q;
    pop_d      = '0;
    push_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d        = win;
          pop_d[win] = 1'b1;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        pkt_d    = D_pop[g_q*WIDTH +: WIDTH];
        rr_ptr_d = g_q;
        state_d  = S_DECODE;
      end
      S_DECODE, S_WAIT: begin
        if (!dest_valid) begin
          state_d = S_DROP;
        end else if (credit_ok) begin
          push_d   = dest_mask;
          d_push_d = pkt_q;
          state_d  = S_PUSH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_PUSH: state_d = S_IDLE;
      S_DROP: begin
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push and a return on the same port cancel; returns beyond CREDITS are ignored.
  always_comb begin
    for (int i = 0; i < DRVS; i++) begin
      credit_d[i] = credit_q[i];
      if (push_q[i] && !credit_ret[i]) begin
        credit_d[i] = credit_q[i] - 4'd1;
      end else if (!push_q[i] && credit_ret[i] && credit_q[i] != 4'(CREDITS)) begin
        credit_d[i] = credit_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      rr_ptr_q   <= IDX_W'(DRVS - 1);
      pkt_q      <= '0;
      d_push_q   <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DRVS; i++) credit_q[i] <= 4'(CREDITS);
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_q      <= pkt_d;
      d_push_q   <= d_push_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < DRVS; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_credit_scheduler.sv
// Testbench for bus_credit_scheduler: directed vector table, corner-case sequences and a
// randomized run against a transaction-level model of arbitration, credits and drops.
module tb_bus_credit_scheduler;
  localparam int WIDTH   = 16;
  localparam int DRVS    = 8;
  localparam int ID_W    = 8;
  localparam int CREDITS = 4;
`ifdef BUS_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DRVS-1:0]       pndng, pop, push, credit_ret;
  logic [DRVS*WIDTH-1:0] D_pop;
  logic [WIDTH-1:0]      D_push;
  logic                  busy;
  logic [7:0]            drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_credit_scheduler dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .credit_ret(credit_ret), .busy(busy), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int               src;
    logic [WIDTH-1:0] pkt;
    logic [DRVS-1:0]  exp_push;
    int               exp_drop;
  } vec_t;

  vec_t             vecs [7];
  logic [WIDTH-1:0] srcq [DRVS][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pndng = '0; D_pop = '0; credit_ret = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rand_pkt();
    int r;
    logic [7:0] d;
    r = $urandom_range(0, 19);
    if (r < 16) d = 8'(r % 8);
    else if (r < 18) d = 8'hFF;
    else d = 8'($urandom_range(8, 247));
    return {d, 8'($urandom)};
  endfunction

  function automatic logic [DRVS-1:0] targets(input logic [WIDTH-1:0] p, input int src);
    int d;
    d = int'(p[WIDTH-1 -: ID_W]);
    if (d < DRVS) return DRVS'(1) << d;
    if (BCAST && d == 255) return ~(DRVS'(1) << src);
    return '0;
  endfunction

  task automatic run_random();
    int occ [DRVS];
    int last_g, idle_start, armed, t_pop, g_exp, model_drops, left;
    bit inflight, all_free;
    logic [DRVS-1:0]  tmask, exp_pop, exp_push, prev_pndng, ret;
    logic [WIDTH-1:0] pkt;
    do_reset();
    for (int i = 0; i < DRVS; i++) begin occ[i] = 0; srcq[i].delete(); end
    last_g = DRVS - 1; idle_start = 0; inflight = 0; armed = -1; t_pop = 0;
    model_drops = 0; prev_pndng = '0; tmask = '0; pkt = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      check("rnd drop_cnt", 32'(drop_cnt), 32'(model_drops));
      exp_pop = '0; g_exp = -1;
      if (!inflight && c - 1 >= idle_start && prev_pndng != '0) begin
        for (int k = 1; k <= DRVS; k++)
          if (g_exp < 0 && prev_pndng[(last_g + k) % DRVS]) g_exp = (last_g + k) % DRVS;
      end
      if (g_exp >= 0) exp_pop[g_exp] = 1'b1;
      check("rnd pop", 32'(pop), 32'(exp_pop));
      if (g_exp >= 0) begin
        inflight = 1; t_pop = c; last_g = g_exp; pkt = srcq[g_exp][0];
        tmask = targets(pkt, g_exp); armed = -1; idle_start = 1 << 30;
      end
      check("rnd busy", 32'(busy), 32'(inflight || c < idle_start));
      exp_push = (inflight && tmask != '0 && armed == c) ? tmask : '0;
      check("rnd push", 32'(push), 32'(exp_push));
      if (exp_push != '0) begin
        check("rnd d_push", 32'(D_push), 32'(pkt));
        for (int i = 0; i < DRVS; i++) if (tmask[i]) occ[i]++;
        inflight = 0; idle_start = c + 1;
      end
      if (inflight && tmask == '0 && c == t_pop + 2) begin
        if (model_drops < 255) model_drops++;
        inflight = 0; idle_start = c + 1;
      end
      if (inflight && tmask != '0 && armed < 0 && c >= t_pop + 1) begin
        all_free = 1;
        for (int i = 0; i < DRVS; i++) if (tmask[i] && occ[i] >= CREDITS) all_free = 0;
        if (all_free) armed = c + 1;
      end
      pndng = '0; D_pop = '0;
      for (int i = 0; i < DRVS; i++) begin
        if (srcq[i].size() > 0) begin
          pndng[i] = 1'b1;
          D_pop[i*WIDTH +: WIDTH] = srcq[i][0];
        end
      end
      prev_pndng = pndng;
      ret = '0;
      for (int i = 0; i < DRVS; i++) begin
        if ((occ[i] > 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 15) == 0) begin
          ret[i] = 1'b1;
          if (occ[i] > 0) occ[i]--;
        end
      end
      credit_ret = ret;
      if (g_exp >= 0) void'(srcq[g_exp].pop_front());
      if (c < 2600) begin
        for (int i = 0; i < DRVS; i++)
          if (srcq[i].size() < 4 && $urandom_range(0, 9) == 0) srcq[i].push_back(rand_pkt());
      end
    end
    left = 0;
    for (int i = 0; i < DRVS; i++) left += srcq[i].size();
    check("rnd drained", 32'(left), 32'(0));
    check("rnd idle at end", 32'(inflight), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops, idx, npush, npop, first_pop, ng;
    bit pop_prev, anypush;
    logic [DRVS-1:0] gr [9];
    int gc [9];

    vecs[0] = '{0, 16'h0312, 8'h08, 0};
    vecs[1] = '{2, 16'h0255, 8'h04, 0};
    vecs[2] = '{7, 16'h07A5, 8'h80, 0};
    vecs[3] = '{5, 16'h0800, 8'h00, 1};
    vecs[4] = '{3, 16'h0A3C, 8'h00, 1};
`ifdef BUS_BCAST_EN
    vecs[5] = '{2, 16'hFF55, 8'hFB, 0};
`else
    vecs[5] = '{2, 16'hFF55, 8'h00, 1};
`endif
    vecs[6] = '{6, 16'h0066, 8'h01, 0};

    do_reset();
    check("reset pop", 32'(pop), 32'(0));
    check("reset push", 32'(push), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset drop_cnt", 32'(drop_cnt), 32'(0));
    check("reset D_push", 32'(D_push), 32'(0));

    drops = 0;
    for (int v = 0; v < 7; v++) begin
      pndng = '0; pndng[vecs[v].src] = 1'b1;
      D_pop = '0; D_pop[vecs[v].src*WIDTH +: WIDTH] = vecs[v].pkt;
      @(negedge clk);
      check("vec pop", 32'(pop), 32'(DRVS'(1) << vecs[v].src));
      check("vec busy", 32'(busy), 32'(1));
      @(negedge clk);
      pndng = '0;
      check("vec early push", 32'(push), 32'(0));
      @(negedge clk);
      check("vec push", 32'(push), 32'(vecs[v].exp_push));
      if (vecs[v].exp_push != '0) check("vec D_push", 32'(D_push), 32'(vecs[v].pkt));
      drops += vecs[v].exp_drop;
      @(negedge clk);
      check("vec push off", 32'(push), 32'(0));
      check("vec idle", 32'(busy), 32'(0));
      check("vec drop_cnt", 32'(drop_cnt), 32'(drops));
      credit_ret = vecs[v].exp_push;
      @(negedge clk);
      credit_ret = '0;
    end

    // Fair rotation with every source pending and credit always returned
    do_reset();
    pndng = '1; credit_ret = 8'h01;
    for (int i = 0; i < DRVS; i++) D_pop[i*WIDTH +: WIDTH] = {8'h00, 8'(i)};
    ng = 0;
    for (int c = 0; c < 60 && ng < 9; c++) begin
      @(negedge clk);
      if (pop != '0) begin gr[ng] = pop; gc[ng] = c; ng++; end
    end
    pndng = '0;
    check("rr grant count", 32'(ng), 32'(9));
    for (int k = 0; k < ng; k++) begin
      check("rr grant order", 32'(gr[k]), 32'(1) << (k % DRVS));
      if (k > 0) check("rr grant spacing", 32'(gc[k] - gc[k-1]), 32'(4));
    end
    repeat (6) @(negedge clk);
    credit_ret = '0;

    // Five packets to dest 5 with no credit return: fifth waits
    do_reset();
    idx = 0; npush = 0; pop_prev = 0;
    for (int c = 0; c < 40; c++) begin
      if (pop_prev) idx++;
      pop_prev = pop[1];
      if (push != '0) begin
        check("credit push target", 32'(push), 32'(8'h20));
        check("credit push data", 32'(D_push), 32'(16'(16'h0501 + npush)));
        npush++;
      end
      pndng = (idx < 5) ? 8'h02 : 8'h00;
      D_pop[1*WIDTH +: WIDTH] = 16'(16'h0501 + idx);
      @(negedge clk);
    end
    check("credit pushes before wait", 32'(npush), 32'(4));
    check("credit waiting busy", 32'(busy), 32'(1));
    credit_ret = 8'h20;
    @(negedge clk);
    credit_ret = '0;
    check("credit push not yet", 32'(push), 32'(0));
    @(negedge clk);
    check("credit fifth push", 32'(push), 32'(8'h20));
    check("credit fifth data", 32'(D_push), 32'(16'h0505));

    // Reset while waiting for credit, other sources blocked meanwhile
    @(negedge clk);
    pndng = 8'h08; D_pop[3*WIDTH +: WIDTH] = 16'h05C3; D_pop[6*WIDTH +: WIDTH] = 16'h0266;
    @(negedge clk);
    check("wait pop src3", 32'(pop), 32'(8'h08));
    @(negedge clk);
    pndng = 8'h40;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("wait blocked", 32'({pop, push}), 32'(0));
      check("wait busy", 32'(busy), 32'(1));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst push", 32'(push), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst pop", 32'(pop), 32'(0));
    pndng = 8'h41; D_pop[0*WIDTH +: WIDTH] = 16'h0511;
    @(negedge clk);
    check("rst first grant", 32'(pop), 32'(8'h01));
    pndng = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst credit restored push", 32'(push), 32'(8'h20));
    check("rst credit restored data", 32'(D_push), 32'(16'h0511));
    @(negedge clk);

    // Drop counter saturation
    do_reset();
    npop = 0; anypush = 0; first_pop = -1;
    pndng = 8'h10; D_pop[4*WIDTH +: WIDTH] = 16'h0A00;
    for (int c = 0; c < 1200 && npop < 256; c++) begin
      @(negedge clk);
      if (pop != '0) begin
        npop++;
        if (npop == 1) first_pop = c;
      end
      if (push != '0) anypush = 1;
      if (first_pop >= 0 && c == first_pop + 3) check("drop first", 32'(drop_cnt), 32'(1));
    end
    pndng = '0;
    repeat (5) @(negedge clk);
    check("drop packets", 32'(npop), 32'(256));
    check("drop saturate", 32'(drop_cnt), 32'(255));
    check("drop no push", 32'(anypush), 32'(0));

    run_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
